// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-stream program loader for the riscv_top instruction memory.
// It holds the core in reset while it receives a length header, the data words and a
// closing XOR checksum. It writes each little-endian word to imem and releases the core
// reset only when the checksum matches.
//
// state   | meaning
// S_LEN0  | waiting for word-count low byte
// S_LEN1  | waiting for word-count high byte, range check
// S_DATA  | assembling 4-byte words and writing imem
// S_CSUM  | waiting for XOR checksum byte
// S_DONE  | load good, core released; holds
// S_ERR   | overflow or checksum mismatch; holds until restart/rst
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Capacity is one larger than the largest address, so it needs ADDR_W+1 bits.
  localparam logic [16:0]   LP_CAP   = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] LP_ONE_W = 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_len;
  logic [1:0]          r_byte_idx;
  logic [ADDR_W:0]     r_word_idx;
  logic [23:0]         r_word;
  logic [7:0]          r_csum;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [15:0]         r_words_loaded;
  logic                r_core_rst;
  logic                r_done;
  logic                r_err;

  logic                w_ready_state;
  logic                w_accept;
  logic [16:0]         w_len_full;
  logic [15:0]         w_word_idx_inc;
  logic                w_word_last;

  assign w_ready_state = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM);
  // rst gating keeps s_ready low during the async reset window.
  assign s_ready       = rst & ~restart & w_ready_state;
  assign w_accept      = s_valid & s_ready;
  assign w_len_full    = {1'b0, s_data, r_len[7:0]};
  assign w_word_idx_inc = 16'(r_word_idx) + 16'd1;
  assign w_word_last   = (w_word_idx_inc == r_len);

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign core_rst     = r_core_rst;
  assign load_done    = r_done;
  assign load_err     = r_err;
  assign words_loaded = r_words_loaded;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_LEN0;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; restart overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = S_LEN0;
    end else begin
      case (r_state)
        S_LEN0: if (w_accept) w_state_nxt = S_LEN1;
        S_LEN1: begin
          if (w_accept) begin
            if (w_len_full > LP_CAP)     w_state_nxt = S_ERR;
            else if (w_len_full == '0)   w_state_nxt = S_CSUM;
            else                         w_state_nxt = S_DATA;
          end
        end
        S_DATA: if (w_accept && (r_byte_idx == 2'd3) && w_word_last) w_state_nxt = S_CSUM;
        S_CSUM: begin
          if (w_accept) w_state_nxt = (s_data == r_csum) ? S_DONE : S_ERR;
        end
        S_DONE:  w_state_nxt = S_DONE;
        S_ERR:   w_state_nxt = S_ERR;
        default: w_state_nxt = S_LEN0;
      endcase
    end
  end

  // Datapath: header capture, word assembly, checksum, imem write pulse, status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len          <= '0;
      r_byte_idx     <= '0;
      r_word_idx     <= '0;
      r_word         <= '0;
      r_csum         <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_words_loaded <= '0;
      r_core_rst     <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      // Status follows the next state so it appears the cycle after the deciding byte.
      r_done     <= (w_state_nxt == S_DONE);
      r_core_rst <= (w_state_nxt == S_DONE);
      r_err      <= (w_state_nxt == S_ERR);
      if (restart) begin
        r_len          <= '0;
        r_byte_idx     <= '0;
        r_word_idx     <= '0;
        r_word         <= '0;
        r_csum         <= '0;
        r_words_loaded <= '0;
      end else if (w_accept) begin
        case (r_state)
          S_LEN0: r_len[7:0]  <= s_data;
          S_LEN1: r_len[15:8] <= s_data;
          S_DATA: begin
            r_csum     <= r_csum ^ s_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= s_data;
              2'd1: r_word[15:8]  <= s_data;
              2'd2: r_word[23:16] <= s_data;
              default: begin
                r_we           <= 1'b1;
                r_addr         <= r_word_idx[ADDR_W-1:0];
                r_wdata        <= {s_data, r_word};
                r_word_idx     <= r_word_idx + LP_ONE_W;
                r_words_loaded <= r_words_loaded + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write scoreboard.
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              restart;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              load_err;
  logic [15:0]       words_loaded;

  int checks   = 0;
  int failures = 0;
  logic [39:0] sb[$];   // {addr, data} of expected imem writes

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every imem write must match the head of the queue.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {24'd0, imem_addr, imem_wdata}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 64'(imem_addr), 64'(e[39:32]));
          chk("wr_data", 64'(imem_wdata), 64'(e[31:0]));
        end
      end
    end
  end

  // Drive one byte starting at posedge+1, hold until accepted; returns at posedge+1.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    if (!s_ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int gmax);
    return (gmax == 0) ? 0 : int'($urandom_range(gmax, 1));
  endfunction

  task automatic run_stream(input logic [31:0] words[$], input bit bad_csum, input int gmax);
    int n;
    logic [7:0] cs;
    logic [7:0] b;
    logic [31:0] w;
    n  = words.size();
    cs = 8'h00;
    send(n[7:0], pick_gap(gmax));
    send(n[15:8], pick_gap(gmax));
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        b  = w[8*k +: 8];
        cs = cs ^ b;
        if (k == 3) sb.push_back({i[7:0], w});
        send(b, pick_gap(gmax));
      end
    end
    send(bad_csum ? (cs ^ 8'h01) : cs, pick_gap(gmax));
  endtask

  task automatic check_result(input string tag, input logic done, input logic err,
                              input logic crst, input logic [15:0] wl);
    @(negedge clk);
    chk({tag, "_done"}, 64'(load_done), 64'(done));
    chk({tag, "_err"}, 64'(load_err), 64'(err));
    chk({tag, "_core_rst"}, 64'(core_rst), 64'(crst));
    chk({tag, "_words"}, 64'(words_loaded), 64'(wl));
    chk({tag, "_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    s_valid = 1'b1;   // this byte must be ignored
    s_data  = 8'h05;
    #1;
    chk("ready_in_restart", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    restart = 1'b0;
    s_valid = 1'b0;
    chk("rs_done", 64'(load_done), 64'd0);
    chk("rs_err", 64'(load_err), 64'd0);
    chk("rs_core_rst", 64'(core_rst), 64'd0);
    chk("rs_words", 64'(words_loaded), 64'd0);
    chk("rs_we", 64'(imem_we), 64'd0);
  endtask

  initial begin
    logic [31:0] w1[$];
    logic [31:0] w0[$];
    logic [31:0] wbig[$];
    w1 = '{32'h00500013, 32'h00700093};
    w0 = {};
    rst = 1'b0; restart = 1'b0; s_valid = 1'b0; s_data = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_core_rst", 64'(core_rst), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    rst = 1'b1;
    #1;
    chk("ready_after_rst", 64'(s_ready), 64'd1);

    // Case 1: good two-word load
    run_stream(w1, 1'b0, 0);
    check_result("c1", 1'b1, 1'b0, 1'b1, 16'd2);
    chk("c1_addr_hold", 64'(imem_addr), 64'd1);
    chk("c1_wdata_hold", 64'(imem_wdata), 64'h00700093);

    // Case 2: bad checksum
    do_restart();
    run_stream(w1, 1'b1, 0);
    check_result("c2", 1'b0, 1'b1, 1'b0, 16'd2);

    // Case 3: empty program
    do_restart();
    run_stream(w0, 1'b0, 0);
    check_result("c3", 1'b1, 1'b0, 1'b1, 16'd0);

    // Case 4: length 257 overflows 256-word imem
    do_restart();
    send(8'h01, 0);
    send(8'h01, 0);
    check_result("c4", 1'b0, 1'b1, 1'b0, 16'd0);

    // Case 5a: idle gaps between bytes
    do_restart();
    run_stream(w1, 1'b0, 3);
    check_result("c5a", 1'b1, 1'b0, 1'b1, 16'd2);

    // Case 5b: restart after two data bytes discards the partial word
    do_restart();
    send(8'h02, 0); send(8'h00, 0); send(8'h13, 0); send(8'h00, 0);
    do_restart();
    run_stream(w1, 1'b0, 0);
    check_result("c5b", 1'b1, 1'b0, 1'b1, 16'd2);

    // Case 6: async reset mid-load after 5 data bytes
    do_restart();
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h50, 0);
    sb.push_back({8'h00, 32'h00500013});
    send(8'h00, 0);
    send(8'h93, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("c6_ready", 64'(s_ready), 64'd0);
    chk("c6_we", 64'(imem_we), 64'd0);
    chk("c6_addr", 64'(imem_addr), 64'd0);
    chk("c6_wdata", 64'(imem_wdata), 64'd0);
    chk("c6_words", 64'(words_loaded), 64'd0);
    chk("c6_core_rst", 64'(core_rst), 64'd0);
    chk("c6_sb_empty", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_stream(w1, 1'b0, 0);
    check_result("c6", 1'b1, 1'b0, 1'b1, 16'd2);

    // Boundary: exactly 256 words fills imem without wrapping
    do_restart();
    wbig = {};
    for (int i = 0; i < 256; i++) wbig.push_back($urandom);
    run_stream(wbig, 1'b0, 0);
    check_result("cap", 1'b1, 1'b0, 1'b1, 16'd256);
    chk("cap_last_addr", 64'(imem_addr), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
